wash_phase_timer: RTL and testbench
===================================

# wash_phase_timer

Parametrised phase timer for the washing-machine controller. Generates minute ticks internally from a prescaler scaled by the selected clock option, so no external timer handshake is needed. Counts the per-phase duration for the current FSM state and issues one-cycle done pulses back to the FSM. Adds a per-state pause mask and a remaining-minutes readout.

## Interface
Parameters:
- TICKS_BASE, default 2: clock cycles per minute at clock option CLK1. Must be ≥1.
- MIN_W, default 4: width of the minute counter and of RemainMinutes.
- FILL_MIN, default 2: FillingWater duration in minutes.
- WASH_MIN, default 5: Washing duration in minutes.
- RINSE_MIN, default 2: Rinsing duration in minutes.
- SPIN_MIN, default 1: Spinning duration in minutes.
- PAUSE_MASK, default 4'b0001: per-state pause enable. Bit order is {Fill, Wash, Rinse, Spin}, the same one-hot order as DoneFlags.

Ports:
- CLK, input, 1: single clock.
- RST, input, 1: asynchronous, active-low reset.
- clk_freq, input, 2: clock option. 00=CLK1, 01=CLK2, 10=CLK4, 11=CLK8.
- current_state, input, 3: FSM state. 0=IDLE, 1=FillingWater, 2=Washing, 3=Rinsing, 4=Spinning; 5–7 are invalid.
- TimerPause, input, 1: pause request.
- DoneFlags, output, 4: one-hot, single-cycle done pulse. 1000=Fill, 0100=Wash, 0010=Rinse, 0001=Spin.
- TimerMode, output, 2: 00=RUN, 01=PAUSE, 10=STOP.
- RemainMinutes, output, MIN_W: minutes left in the current phase.
- MinuteTick, output, 1: one-cycle pulse at the end of each counted minute.

## Operation
- Tick period T = TICKS_BASE << clk_freq. clk_freq is latched once per phase, at entry; changes mid-phase take effect at the next entry.
- Entry detection uses an internal prev_state register, reset to IDLE. The entry cycle is the first cycle in which current_state differs from prev_state and is an active state (1–4).
- At the end of the entry cycle:
  - the tick counter loads T−1;
  - RemainMinutes loads the phase duration;
  - the done latch clears.
- Running: each cycle that is not paused, not done and not an entry cycle, the tick counter decrements.
- When the tick counter is 0:
  - the tick counter reloads T−1;
  - MinuteTick pulses;
  - RemainMinutes decrements.
- If that decrement is 1→0, the matching DoneFlags bit pulses in the same cycle and the done latch sets.
- Pause condition: TimerPause and PAUSE_MASK[bit of current_state]. All counters hold; no tick. TimerPause in an unmasked state is ignored.
- TimerMode (combinational), in priority order:
  1. STOP if IDLE, invalid state, or done latch set;
  2. PAUSE if the pause condition holds;
  3. otherwise RUN.
- IDLE or invalid state: tick counter, RemainMinutes and the done latch clear to 0. DoneFlags = 0.
- Phase durations must be in 1..2^MIN_W−1; elaboration fails otherwise.

## Timing
- Reset values: DoneFlags=0, TimerMode=STOP (IDLE), RemainMinutes=0, MinuteTick=0, internal counters 0.
- Let E be the entry cycle, with no pauses. MinuteTick for minute n is high in cycle E+n·T. DoneFlags is high in cycle E+D·T, where D is the phase duration.
- Each paused cycle delays all later events by exactly one cycle.
- DoneFlags and MinuteTick are registered, high for exactly one cycle, and never asserted in IDLE.
- Simultaneous events:
  - State change in the same cycle as a final tick: the new-phase load wins. The old phase's done pulse is suppressed.
  - Pause in the same cycle as a tick: the pause wins and the tick is deferred.
- State change mid-phase, including back into the same phase via IDLE, restarts timing from the full duration.
- Reset mid-phase: all outputs return to reset values immediately (asynchronously). The first active state seen after reset release is treated as an entry.
- After done, counters hold and TimerMode=STOP until current_state changes.

## Structure
- Shared package wash_timer_pkg holds:
  - state encodings;
  - DoneFlags one-hot constants;
  - TimerMode constants;
  - clock-option constants.
- Sub-module minute_prescaler:
  - contains the loadable down-counter, width $clog2(TICKS_BASE·8);
  - inputs: load, period, enable;
  - output: the tick pulse.
- The top level holds entry detection, the minute counter, the done latch and mode decode.

## Test plan
All scenarios use default parameters.
1. Reset, then current_state=1, clk_freq=00 (T=2) → MinuteTick in cycles E+2 and E+4; DoneFlags=1000 only in cycle E+4; then TimerMode=STOP and RemainMinutes=0.
2. Washing with clk_freq=11 (T=16) → DoneFlags=0100 in cycle E+80. Changing clk_freq to 00 mid-phase does not change this.
3. Spinning, TimerPause high for 10 cycles mid-minute → TimerMode=PAUSE during the pause; DoneFlags=0001 in cycle E+2+10. The same pause during Washing is ignored.
4. Rinsing: switch to IDLE at E+3, then back to Rinsing → RemainMinutes returns to 0 in IDLE, reloads 2 at re-entry, and no 0010 pulse occurs before the new E+4.
5. Change state in the exact cycle of Fill's final tick → no 1000 pulse; RemainMinutes loads the next phase's duration.
6. Assert RST mid-Washing → outputs return to reset values immediately. After release with state still Washing, a full 5-minute count restarts.

Source files
------------

// File: rtl/wash_timer_pkg.sv
// Shared encodings for the washing-machine phase timer: FSM states,
// done-pulse one-hots, timer modes and clock options.
package wash_timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4
  } state_e;

  localparam logic [3:0] DONE_NONE  = 4'b0000;
  localparam logic [3:0] DONE_FILL  = 4'b1000;
  localparam logic [3:0] DONE_WASH  = 4'b0100;
  localparam logic [3:0] DONE_RINSE = 4'b0010;
  localparam logic [3:0] DONE_SPIN  = 4'b0001;

  localparam logic [1:0] MODE_RUN   = 2'b00;
  localparam logic [1:0] MODE_PAUSE = 2'b01;
  localparam logic [1:0] MODE_STOP  = 2'b10;

  localparam logic [1:0] CLK1 = 2'b00;
  localparam logic [1:0] CLK2 = 2'b01;
  localparam logic [1:0] CLK4 = 2'b10;
  localparam logic [1:0] CLK8 = 2'b11;

  // True for the four timed phases; IDLE and the unused codes 5-7 are not.
  function automatic logic is_active(input logic [2:0] s);
    return (s >= ST_FILL) && (s <= ST_SPIN);
  endfunction

  // Done pulse pattern belonging to a phase.
  function automatic logic [3:0] done_onehot(input logic [2:0] s);
    case (s)
      ST_FILL:  return DONE_FILL;
      ST_WASH:  return DONE_WASH;
      ST_RINSE: return DONE_RINSE;
      ST_SPIN:  return DONE_SPIN;
      default:  return DONE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// Bundle between the washer FSM (master) and the phase timer (slave).
interface wash_phase_timer_if #(
  parameter int MIN_W = 4
);
  logic [1:0]       clk_freq;
  logic [2:0]       current_state;
  logic             TimerPause;
  logic [3:0]       DoneFlags;
  logic [1:0]       TimerMode;
  logic [MIN_W-1:0] RemainMinutes;
  logic             MinuteTick;

  modport master (
    output clk_freq, current_state, TimerPause,
    input  DoneFlags, TimerMode, RemainMinutes, MinuteTick
  );

  modport slave (
    input  clk_freq, current_state, TimerPause,
    output DoneFlags, TimerMode, RemainMinutes, MinuteTick
  );
endinterface

// File: rtl/minute_prescaler.sv
// Loadable down-counter that divides the clock into minute ticks.
// The counter runs period-1 .. 0; the tick is the cycle it sits at 0
// while enabled, and that same cycle reloads period-1.
module minute_prescaler #(
  parameter int TICKS_BASE = 2,
  parameter int CW         = $clog2(TICKS_BASE * 8)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic [CW:0] period,
  input  logic        enable,
  output logic        tick
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] reload;

  assign reload = CW'(period - (CW+1)'(1));

  // Tick whenever an enabled count reaches zero; a load always takes priority.
  always_comb begin
    tick = enable && !load && (cnt_reg == '0);
  end

  // Next count: load, wrap on tick, or decrement while enabled.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = reload;
    end else if (enable) begin
      cnt_next = (cnt_reg == '0) ? reload : cnt_reg - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/wash_phase_timer.sv
// Phase timer for the washer FSM: detects phase entry, counts the phase
// duration in minutes, and reports done pulses, mode and time remaining.
// Tick and done outputs are decoded from registered counters but gated by
// this cycle's state and pause, so a state change or pause landing on a
// tick cycle suppresses that tick.
module wash_phase_timer
  import wash_timer_pkg::*;
#(
  parameter int         TICKS_BASE = 2,
  parameter int         MIN_W      = 4,
  parameter int         FILL_MIN   = 2,
  parameter int         WASH_MIN   = 5,
  parameter int         RINSE_MIN  = 2,
  parameter int         SPIN_MIN   = 1,
  parameter logic [3:0] PAUSE_MASK = 4'b0001
) (
  input logic               CLK,
  input logic               RST,
  wash_phase_timer_if.slave bus
);

  localparam int               CW    = $clog2(TICKS_BASE * 8);
  localparam logic [CW:0]      TB_W  = (CW+1)'(TICKS_BASE);
  localparam logic [CW:0]      ONE_W = (CW+1)'(1);
  localparam logic [MIN_W-1:0] ONE_M = MIN_W'(1);
  localparam int               MAX_M = (1 << MIN_W) - 1;

  if (TICKS_BASE < 1) begin : g_bad_ticks
    $error("wash_phase_timer: TICKS_BASE must be at least 1");
  end
  if (FILL_MIN < 1 || FILL_MIN > MAX_M || WASH_MIN < 1 || WASH_MIN > MAX_M ||
      RINSE_MIN < 1 || RINSE_MIN > MAX_M || SPIN_MIN < 1 || SPIN_MIN > MAX_M) begin : g_bad_dur
    $error("wash_phase_timer: phase durations must fit in 1..2^MIN_W-1");
  end

  logic [2:0]       prev_state_reg;
  logic [1:0]       freq_reg, freq_next;
  logic [MIN_W-1:0] remain_reg, remain_next;
  logic             done_reg, done_next;

  logic             active, entry, pause_bit, paused, running;
  logic             tick, final_tick, load;
  logic [CW:0]      period;
  logic [MIN_W-1:0] phase_min;

  assign active     = is_active(bus.current_state);
  assign entry      = active && (bus.current_state != prev_state_reg);
  assign paused     = bus.TimerPause && pause_bit;
  assign running    = active && !entry && !paused && !done_reg;
  assign final_tick = tick && (remain_reg == ONE_M);
  assign load       = entry || !active;

  // Per-state pause enable and phase duration lookup.
  always_comb begin
    pause_bit = 1'b0;
    phase_min = '0;
    case (bus.current_state)
      ST_FILL:  begin pause_bit = PAUSE_MASK[3]; phase_min = MIN_W'(FILL_MIN);  end
      ST_WASH:  begin pause_bit = PAUSE_MASK[2]; phase_min = MIN_W'(WASH_MIN);  end
      ST_RINSE: begin pause_bit = PAUSE_MASK[1]; phase_min = MIN_W'(RINSE_MIN); end
      ST_SPIN:  begin pause_bit = PAUSE_MASK[0]; phase_min = MIN_W'(SPIN_MIN);  end
      default:  begin pause_bit = 1'b0;          phase_min = '0;                end
    endcase
  end

  // Tick period: fresh clock option on entry, latched option mid-phase, and
  // a period of 1 (counter cleared to 0) outside the timed phases.
  always_comb begin
    if (!active) begin
      period = ONE_W;
    end else if (entry) begin
      period = TB_W << bus.clk_freq;
    end else begin
      period = TB_W << freq_reg;
    end
  end

  minute_prescaler #(
    .TICKS_BASE (TICKS_BASE),
    .CW         (CW)
  ) u_prescaler (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .period (period),
    .enable (running),
    .tick   (tick)
  );

  // Next minute count, done latch and latched clock option.
  always_comb begin
    remain_next = remain_reg;
    done_next   = done_reg;
    freq_next   = freq_reg;
    if (!active) begin
      remain_next = '0;
      done_next   = 1'b0;
    end else if (entry) begin
      remain_next = phase_min;
      done_next   = 1'b0;
      freq_next   = bus.clk_freq;
    end else if (tick) begin
      remain_next = remain_reg - ONE_M;
      if (remain_reg == ONE_M) begin
        done_next = 1'b1;
      end
    end
  end

  // Phase state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prev_state_reg <= ST_IDLE;
      freq_reg       <= CLK1;
      remain_reg     <= '0;
      done_reg       <= 1'b0;
    end else begin
      prev_state_reg <= bus.current_state;
      freq_reg       <= freq_next;
      remain_reg     <= remain_next;
      done_reg       <= done_next;
    end
  end

  // Output decode; reset forces STOP even while the FSM still shows a phase.
  always_comb begin
    bus.MinuteTick    = tick;
    bus.RemainMinutes = remain_reg;
    bus.DoneFlags     = final_tick ? done_onehot(bus.current_state) : DONE_NONE;
    if (!RST || !active || done_reg) begin
      bus.TimerMode = MODE_STOP;
    end else if (paused) begin
      bus.TimerMode = MODE_PAUSE;
    end else begin
      bus.TimerMode = MODE_RUN;
    end
  end

endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed bench for wash_phase_timer with default parameters.
// Cycle k of a scenario: inputs change 1 time unit after the k-th rising
// edge, outputs are sampled on the following falling edge.
module tb_wash_phase_timer;
  import wash_timer_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wash_phase_timer_if #(.MIN_W(4)) bus ();

  wash_phase_timer #(
    .TICKS_BASE (2),
    .MIN_W      (4),
    .FILL_MIN   (2),
    .WASH_MIN   (5),
    .RINSE_MIN  (2),
    .SPIN_MIN   (1),
    .PAUSE_MASK (4'b0001)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic go_idle();
    bus.current_state = ST_IDLE;
    bus.TimerPause    = 1'b0;
    bus.clk_freq      = CLK1;
    repeat (3) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    bus.current_state = ST_IDLE;
    bus.TimerPause    = 1'b0;
    bus.clk_freq      = CLK1;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++; if (bus.DoneFlags !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b exp=0000", bus.DoneFlags); end
    checks++; if (bus.TimerMode !== MODE_STOP) begin errors++; $display("FAIL reset_mode got=%b exp=%b", bus.TimerMode, MODE_STOP); end
    checks++; if (bus.RemainMinutes !== 4'd0) begin errors++; $display("FAIL reset_remain got=%0d exp=0", bus.RemainMinutes); end
    checks++; if (bus.MinuteTick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", bus.MinuteTick); end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (bus.TimerMode !== MODE_STOP) begin errors++; $display("FAIL idle_mode got=%b exp=%b", bus.TimerMode, MODE_STOP); end
    $display("scenario reset: idle outputs checked");
  endtask

  task automatic test_fill_basic();
    logic       exp_tick;
    logic [3:0] exp_done;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      bus.current_state = ST_FILL;
      bus.clk_freq      = CLK1;
      @(negedge CLK);
      exp_tick = (k == 2) || (k == 4);
      exp_done = (k == 4) ? DONE_FILL : DONE_NONE;
      checks++; if (bus.MinuteTick !== exp_tick) begin errors++; $display("FAIL fill_tick k=%0d got=%b exp=%b", k, bus.MinuteTick, exp_tick); end
      checks++; if (bus.DoneFlags !== exp_done) begin errors++; $display("FAIL fill_done k=%0d got=%b exp=%b", k, bus.DoneFlags, exp_done); end
      if (k == 1) begin
        checks++; if (bus.RemainMinutes !== 4'd2) begin errors++; $display("FAIL fill_remain_load got=%0d exp=2", bus.RemainMinutes); end
      end
      if (k == 3) begin
        checks++; if (bus.RemainMinutes !== 4'd1) begin errors++; $display("FAIL fill_remain_mid got=%0d exp=1", bus.RemainMinutes); end
      end
    end
    checks++; if (bus.TimerMode !== MODE_STOP) begin errors++; $display("FAIL fill_end_mode got=%b exp=%b", bus.TimerMode, MODE_STOP); end
    checks++; if (bus.RemainMinutes !== 4'd0) begin errors++; $display("FAIL fill_end_remain got=%0d exp=0", bus.RemainMinutes); end
    $display("scenario fill_basic: T=2, done expected at E+4");
  endtask

  task automatic test_wash_clk8();
    logic       exp_tick;
    logic [3:0] exp_done;
    for (int k = 0; k < 86; k++) begin
      @(posedge CLK); #1;
      bus.current_state = ST_WASH;
      bus.clk_freq      = (k < 5) ? CLK8 : CLK1;
      @(negedge CLK);
      exp_tick = (k > 0) && (k % 16 == 0) && (k <= 80);
      exp_done = (k == 80) ? DONE_WASH : DONE_NONE;
      checks++; if (bus.MinuteTick !== exp_tick) begin errors++; $display("FAIL wash8_tick k=%0d got=%b exp=%b", k, bus.MinuteTick, exp_tick); end
      checks++; if (bus.DoneFlags !== exp_done) begin errors++; $display("FAIL wash8_done k=%0d got=%b exp=%b", k, bus.DoneFlags, exp_done); end
    end
    checks++; if (bus.TimerMode !== MODE_STOP) begin errors++; $display("FAIL wash8_end_mode got=%b exp=%b", bus.TimerMode, MODE_STOP); end
    $display("scenario wash_clk8: T=16, done expected at E+80");
  endtask

  task automatic test_pause();
    logic [3:0] exp_done;
    // Spinning: pause is masked in, so it stretches the phase.
    for (int k = 0; k < 15; k++) begin
      @(posedge CLK); #1;
      bus.current_state = ST_SPIN;
      bus.TimerPause    = (k >= 1) && (k <= 10);
      @(negedge CLK);
      exp_done = (k == 12) ? DONE_SPIN : DONE_NONE;
      checks++; if (bus.DoneFlags !== exp_done) begin errors++; $display("FAIL spin_done k=%0d got=%b exp=%b", k, bus.DoneFlags, exp_done); end
      if (k >= 1 && k <= 10) begin
        checks++; if (bus.TimerMode !== MODE_PAUSE) begin errors++; $display("FAIL spin_pause_mode k=%0d got=%b exp=%b", k, bus.TimerMode, MODE_PAUSE); end
      end
      if (k == 11) begin
        checks++; if (bus.TimerMode !== MODE_RUN) begin errors++; $display("FAIL spin_resume_mode got=%b exp=%b", bus.TimerMode, MODE_RUN); end
      end
    end
    go_idle();
    // Washing: pause is masked out and must be ignored.
    for (int k = 0; k < 13; k++) begin
      @(posedge CLK); #1;
      bus.current_state = ST_WASH;
      bus.TimerPause    = (k >= 1) && (k <= 10);
      @(negedge CLK);
      exp_done = (k == 10) ? DONE_WASH : DONE_NONE;
      checks++; if (bus.DoneFlags !== exp_done) begin errors++; $display("FAIL wash_nopause_done k=%0d got=%b exp=%b", k, bus.DoneFlags, exp_done); end
      if (k >= 1 && k <= 10) begin
        checks++; if (bus.TimerMode !== MODE_RUN) begin errors++; $display("FAIL wash_nopause_mode k=%0d got=%b exp=%b", k, bus.TimerMode, MODE_RUN); end
      end
    end
    bus.TimerPause = 1'b0;
    $display("scenario pause: spin stretched by 10, wash unaffected");
  endtask

  task automatic test_rinse_restart();
    logic [3:0] exp_done;
    for (int k = 0; k < 11; k++) begin
      @(posedge CLK); #1;
      bus.current_state = (k == 3) ? 3'(ST_IDLE) : 3'(ST_RINSE);
      @(negedge CLK);
      exp_done = (k == 8) ? DONE_RINSE : DONE_NONE;
      checks++; if (bus.DoneFlags !== exp_done) begin errors++; $display("FAIL rinse_done k=%0d got=%b exp=%b", k, bus.DoneFlags, exp_done); end
      if (k == 4) begin
        checks++; if (bus.RemainMinutes !== 4'd0) begin errors++; $display("FAIL rinse_idle_remain got=%0d exp=0", bus.RemainMinutes); end
      end
      if (k == 5) begin
        checks++; if (bus.RemainMinutes !== 4'd2) begin errors++; $display("FAIL rinse_reload_remain got=%0d exp=2", bus.RemainMinutes); end
      end
    end
    $display("scenario rinse_restart: re-entry at E+4, done expected at E+8");
  endtask

  task automatic test_back_to_back();
    logic       exp_tick;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      bus.current_state = (k < 4) ? 3'(ST_FILL) : 3'(ST_WASH);
      @(negedge CLK);
      exp_tick = (k == 2) || (k == 6);
      checks++; if (bus.DoneFlags !== DONE_NONE) begin errors++; $display("FAIL b2b_done k=%0d got=%b exp=0000", k, bus.DoneFlags); end
      checks++; if (bus.MinuteTick !== exp_tick) begin errors++; $display("FAIL b2b_tick k=%0d got=%b exp=%b", k, bus.MinuteTick, exp_tick); end
      if (k == 5) begin
        checks++; if (bus.RemainMinutes !== 4'd5) begin errors++; $display("FAIL b2b_remain got=%0d exp=5", bus.RemainMinutes); end
      end
    end
    $display("scenario back_to_back: fill final tick replaced by wash entry");
  endtask

  task automatic test_reset_mid();
    logic       exp_tick;
    logic [3:0] exp_done;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLK); #1;
      bus.current_state = ST_WASH;
      RST = !((k == 5) || (k == 6));
      @(negedge CLK);
      exp_tick = (k == 2) || (k == 4) || (k == 9) || (k == 11) || (k == 13) || (k == 15) || (k == 17);
      exp_done = (k == 17) ? DONE_WASH : DONE_NONE;
      checks++; if (bus.MinuteTick !== exp_tick) begin errors++; $display("FAIL rstmid_tick k=%0d got=%b exp=%b", k, bus.MinuteTick, exp_tick); end
      checks++; if (bus.DoneFlags !== exp_done) begin errors++; $display("FAIL rstmid_done k=%0d got=%b exp=%b", k, bus.DoneFlags, exp_done); end
      if (k == 5) begin
        checks++; if (bus.RemainMinutes !== 4'd0) begin errors++; $display("FAIL rstmid_remain got=%0d exp=0", bus.RemainMinutes); end
        checks++; if (bus.TimerMode !== MODE_STOP) begin errors++; $display("FAIL rstmid_mode got=%b exp=%b", bus.TimerMode, MODE_STOP); end
      end
      if (k == 8) begin
        checks++; if (bus.RemainMinutes !== 4'd5) begin errors++; $display("FAIL rstmid_restart_remain got=%0d exp=5", bus.RemainMinutes); end
      end
    end
    RST = 1'b1;
    $display("scenario reset_mid: restart after release, done expected at k=17");
  endtask

  initial begin
    bus.current_state = ST_IDLE;
    bus.TimerPause    = 1'b0;
    bus.clk_freq      = CLK1;
    test_reset();
    test_fill_basic();
    go_idle();
    test_wash_clk8();
    go_idle();
    test_pause();
    go_idle();
    test_rinse_restart();
    go_idle();
    test_back_to_back();
    go_idle();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
